menu_controlador: RTL and testbench
===================================

Name: menu_controlador

Overview:
- Configuration sequencer for the music-game datapath.
- Walks the player through four menus in order: mode, BPM, key (tom), song. The player moves a cursor with the arrow keys and confirms with enter.
- Drives `menu_sel`, the cursor value and one-cycle `registra_*` strobes so the datapath latches each choice.
- Sits beside the game control unit. It raises `menu_pronto` when configuration is complete; the game FSM then takes over.

Parameters:
- MODO, 4: number of mode options (cursor range 0..MODO-1)
- BPM, 2: number of BPM options
- TOM, 4: number of key options
- MUSICA, 16: number of song options
- CLOCK_FREQ, 50000000: clock frequency in Hz (timeout feature only)
- TIMEOUT_S, 10: inactivity seconds before auto-confirm (timeout feature only)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- inicia_menu  in  1  pulse: start the menu sequence from the mode menu
- right_arrow_pressed  in  1  single-cycle pulse (edge-detected upstream): cursor +1
- left_arrow_pressed  in  1  single-cycle pulse: cursor -1
- enter_pressed  in  1  single-cycle pulse: confirm current option
- menu_sel  out  3  0 idle, 1 mode, 2 BPM, 3 key, 4 song, 5 ready
- opcao  out  4  current cursor value
- registra_modo  out  1  one-cycle strobe; `opcao` is valid during it
- registra_bpm  out  1  one-cycle strobe
- registra_tom  out  1  one-cycle strobe
- registra_musicas  out  1  one-cycle strobe
- menu_pronto  out  1  level: configuration complete
- db_estado  out  4  state encoding for the 7-segment display

Behaviour:
- Reset (asynchronous, any time, including mid-menu):
  - state IDLE, `opcao`=0, `menu_sel`=0
  - all strobes 0, `menu_pronto`=0, `db_estado`=0
- States and `db_estado` codes: IDLE 0, SEL_MODO 1, REG_MODO 2, SEL_BPM 3, REG_BPM 4, SEL_TOM 5, REG_TOM 6, SEL_MUSICA 7, REG_MUSICA 8, PRONTO 9.
- IDLE:
  - `inicia_menu` -> SEL_MODO.
  - Arrows and enter are ignored.
- SEL_x state, option count N:
  - Entering the state clears the cursor to 0 (`opcao`=0 in the first SEL cycle).
  - Right alone: cursor = (cursor==N-1) ? 0 : cursor+1.
  - Left alone: cursor = (cursor==0) ? N-1 : cursor-1.
  - Right and left in the same cycle: cursor unchanged.
  - Enter -> REG_x. Enter wins over any arrow in the same cycle, so the cursor is unchanged.
  - `inicia_menu` in any SEL state restarts at SEL_MODO with cursor 0.
- REG_x:
  - Exactly one cycle.
  - The matching `registra_*` strobe is 1 and `opcao` holds the confirmed value.
  - All inputs are ignored.
  - Next state is the following SEL (MODO -> BPM -> TOM -> MUSICA); REG_MUSICA goes to PRONTO.
- PRONTO:
  - `menu_pronto`=1, `opcao` holds the song index.
  - Arrows and enter are ignored.
  - `inicia_menu` -> SEL_MODO.
- Latency:
  - Enter in SEL cycle t gives the strobe in cycle t+1 and the next menu in cycle t+2.
  - Arrow in cycle t gives the updated `opcao` in cycle t+1.
- Output timing:
  - `menu_sel` is combinational from state: 1 for SEL/REG_MODO, 2 for BPM, 3 for TOM, 4 for MUSICA, 5 for PRONTO, 0 for IDLE.
  - Strobes and `menu_pronto` are Moore outputs, glitch-free from state.
- Width: cursor is 4 bits, so N ≤ 16 per menu. N=1 means arrows leave the cursor at 0.

Optional Feature:
- Macro: MENU_TIMEOUT_EN.
- When defined:
  - An inactivity counter of width ceil(log2(CLOCK_FREQ*TIMEOUT_S+1)) runs in every SEL state.
  - It clears on SEL entry and on any arrow or enter pulse.
  - On reaching CLOCK_FREQ*TIMEOUT_S-1 it acts as enter: the FSM goes to REG_x with the current cursor.
  - The counter holds at 0 outside SEL states.
- When undefined:
  - No counter logic exists.
  - The FSM waits indefinitely in SEL states.

Test Plan:
- Reset, pulse `inicia_menu` -> `menu_sel`=1, `opcao`=0, `db_estado`=1; no strobe.
- In SEL_MODO (MODO=4): right x5 -> `opcao` 1,2,3,0,1; then left x2 -> `opcao` 0,3.
- Full walk:
  - mode: right x2, enter -> `registra_modo` for one cycle with `opcao`=2
  - BPM: right, enter -> `registra_bpm` with `opcao`=1
  - key: enter -> `registra_tom` with 0
  - song: left, enter -> `registra_musicas` with 15
  - end: `menu_pronto`=1, `menu_sel`=5
- Simultaneous inputs:
  - right+left in one cycle -> `opcao` unchanged.
  - right+enter in one cycle with `opcao`=1 -> strobe carries 1.
- Assert `reset` asynchronously in SEL_TOM with `opcao`=3 -> outputs 0 immediately, before the next clock edge; later `inicia_menu` restarts at SEL_MODO.
- With MENU_TIMEOUT_EN, CLOCK_FREQ=10, TIMEOUT_S=1:
  - idle 10 cycles in SEL_BPM with `opcao`=1 -> `registra_bpm` with 1.
  - An arrow pulse at cycle 8 delays the strobe by a further 10 cycles.

Source files
------------

// File: rtl/menu_controlador_if.sv
// rtl/menu_controlador_if.sv - player input pulses and menu outputs of menu_controlador
interface menu_controlador_if;
  logic       inicia_menu;
  logic       right_arrow_pressed;
  logic       left_arrow_pressed;
  logic       enter_pressed;
  logic [2:0] menu_sel;
  logic [3:0] opcao;
  logic       registra_modo;
  logic       registra_bpm;
  logic       registra_tom;
  logic       registra_musicas;
  logic       menu_pronto;
  logic [3:0] db_estado;

  modport master (
    output inicia_menu, right_arrow_pressed, left_arrow_pressed, enter_pressed,
    input  menu_sel, opcao, registra_modo, registra_bpm, registra_tom,
           registra_musicas, menu_pronto, db_estado
  );

  modport slave (
    input  inicia_menu, right_arrow_pressed, left_arrow_pressed, enter_pressed,
    output menu_sel, opcao, registra_modo, registra_bpm, registra_tom,
           registra_musicas, menu_pronto, db_estado
  );
endinterface

// File: rtl/menu_controlador.sv
// rtl/menu_controlador.sv - mode/BPM/key/song configuration sequencer
// Optional inactivity auto-confirm in SEL states: define MENU_TIMEOUT_EN.
module menu_controlador #(
  parameter int MODO       = 4,
  parameter int BPM        = 2,
  parameter int TOM        = 4,
  parameter int MUSICA     = 16,
  parameter int CLOCK_FREQ = 50000000,
  parameter int TIMEOUT_S  = 10
) (
  input logic               clock,
  input logic               reset,
  menu_controlador_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    SEL_MODO   = 4'd1,
    REG_MODO   = 4'd2,
    SEL_BPM    = 4'd3,
    REG_BPM    = 4'd4,
    SEL_TOM    = 4'd5,
    REG_TOM    = 4'd6,
    SEL_MUSICA = 4'd7,
    REG_MUSICA = 4'd8,
    PRONTO     = 4'd9
  } state_t;

  state_t     state, state_n;
  logic [3:0] opcao_q, opcao_n;
  logic       reg_modo_q, reg_bpm_q, reg_tom_q, reg_mus_q, pronto_q;
  logic       timeout_hit;
  logic       activity;

  function automatic logic is_sel(state_t s);
    return s inside {SEL_MODO, SEL_BPM, SEL_TOM, SEL_MUSICA};
  endfunction

  function automatic logic [3:0] last_opt(state_t s);
    case (s)
      SEL_MODO: return 4'(MODO - 1);
      SEL_BPM:  return 4'(BPM - 1);
      SEL_TOM:  return 4'(TOM - 1);
      default:  return 4'(MUSICA - 1);
    endcase
  endfunction

  function automatic logic [2:0] sel_code(state_t s);
    case (s)
      SEL_MODO, REG_MODO:     return 3'd1;
      SEL_BPM, REG_BPM:       return 3'd2;
      SEL_TOM, REG_TOM:       return 3'd3;
      SEL_MUSICA, REG_MUSICA: return 3'd4;
      PRONTO:                 return 3'd5;
      default:                return 3'd0;
    endcase
  endfunction

  assign activity = bus.right_arrow_pressed | bus.left_arrow_pressed | bus.enter_pressed;

  // Encoding places each REG right after its SEL and each next menu right after the REG.
  always_comb begin
    state_n = state;
    opcao_n = opcao_q;
    case (state)
      IDLE, PRONTO: begin
        if (bus.inicia_menu) begin
          state_n = SEL_MODO;
          opcao_n = 4'd0;
        end
      end
      SEL_MODO, SEL_BPM, SEL_TOM, SEL_MUSICA: begin
        if (bus.inicia_menu) begin
          state_n = SEL_MODO;
          opcao_n = 4'd0;
        end else if (bus.enter_pressed || timeout_hit) begin
          state_n = state_t'(state + 4'd1);
        end else if (bus.right_arrow_pressed && !bus.left_arrow_pressed) begin
          opcao_n = (opcao_q == last_opt(state)) ? 4'd0 : opcao_q + 4'd1;
        end else if (bus.left_arrow_pressed && !bus.right_arrow_pressed) begin
          opcao_n = (opcao_q == 4'd0) ? last_opt(state) : opcao_q - 4'd1;
        end
      end
      REG_MODO, REG_BPM, REG_TOM: begin
        state_n = state_t'(state + 4'd1);
        opcao_n = 4'd0;
      end
      REG_MUSICA: state_n = PRONTO;
      default: begin
        state_n = IDLE;
        opcao_n = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      opcao_q    <= 4'd0;
      reg_modo_q <= 1'b0;
      reg_bpm_q  <= 1'b0;
      reg_tom_q  <= 1'b0;
      reg_mus_q  <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      state      <= state_n;
      opcao_q    <= opcao_n;
      reg_modo_q <= (state_n == REG_MODO);
      reg_bpm_q  <= (state_n == REG_BPM);
      reg_tom_q  <= (state_n == REG_TOM);
      reg_mus_q  <= (state_n == REG_MUSICA);
      pronto_q   <= (state_n == PRONTO);
    end
  end

`ifdef MENU_TIMEOUT_EN
  localparam longint unsigned TIMEOUT_CYCLES = longint'(CLOCK_FREQ) * longint'(TIMEOUT_S);
  localparam int              CNT_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] idle_cnt;

  assign timeout_hit = is_sel(state) && (idle_cnt == CNT_LAST);

  // Restart on any menu change (entry, restart, confirm) or player activity.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      idle_cnt <= '0;
    else if (!is_sel(state_n) || state_n != state || activity || bus.inicia_menu)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + CNT_W'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign bus.menu_sel         = sel_code(state);
  assign bus.opcao            = opcao_q;
  assign bus.registra_modo    = reg_modo_q;
  assign bus.registra_bpm     = reg_bpm_q;
  assign bus.registra_tom     = reg_tom_q;
  assign bus.registra_musicas = reg_mus_q;
  assign bus.menu_pronto      = pronto_q;
  assign bus.db_estado        = state;

endmodule

// File: tb/tb_menu_controlador.sv
// tb/tb_menu_controlador.sv - directed and randomized checks of menu_controlador
module tb_menu_controlador;
  localparam int MODO       = 4;
  localparam int BPM        = 2;
  localparam int TOM        = 4;
  localparam int MUSICA     = 16;
  localparam int CLOCK_FREQ = 10;
  localparam int TIMEOUT_S  = 1;
  localparam int TO_CYC     = CLOCK_FREQ * TIMEOUT_S;

  logic clock = 1'b0;
  logic reset = 1'b1;

  menu_controlador_if bus();

  menu_controlador #(
    .MODO(MODO), .BPM(BPM), .TOM(TOM), .MUSICA(MUSICA),
    .CLOCK_FREQ(CLOCK_FREQ), .TIMEOUT_S(TIMEOUT_S)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: menu index 0 idle, 1..4 menus, 5 ready; m_reg marks the confirm cycle.
  int m_menu  = 0;
  int m_cur   = 0;
  int m_quiet = 0;
  bit m_reg   = 1'b0;

  function automatic int n_opt(int menu);
    case (menu)
      1:       return MODO;
      2:       return BPM;
      3:       return TOM;
      default: return MUSICA;
    endcase
  endfunction

  function automatic logic [15:0] obs();
    return {bus.menu_sel, bus.opcao, bus.registra_modo, bus.registra_bpm,
            bus.registra_tom, bus.registra_musicas, bus.menu_pronto, bus.db_estado};
  endfunction

  function automatic logic [15:0] ev(int sel, int op, int strb, bit pr, int db);
    return {3'(sel), 4'(op), 4'(strb), pr, 4'(db)};
  endfunction

  function automatic logic [15:0] model_vec();
    int db;
    int strb;
    if (m_menu == 0)      db = 0;
    else if (m_menu == 5) db = 9;
    else                  db = 2 * m_menu - 1 + (m_reg ? 1 : 0);
    strb = m_reg ? (8 >> (m_menu - 1)) : 0;
    return ev(m_menu, m_cur, strb, m_menu == 5, db);
  endfunction

  task automatic model_reset();
    m_menu  = 0;
    m_cur   = 0;
    m_quiet = 0;
    m_reg   = 1'b0;
  endtask

  task automatic model_step(bit r, bit l, bit e, bit ini);
    bit was_sel;
    bit fire;
    int old_menu;
    was_sel  = (m_menu >= 1 && m_menu <= 4 && !m_reg);
    old_menu = m_menu;
    fire     = 1'b0;
`ifdef MENU_TIMEOUT_EN
    fire = was_sel && (m_quiet == TO_CYC - 1);
`endif
    if (m_reg) begin
      m_reg  = 1'b0;
      m_menu = m_menu + 1;
      if (m_menu < 5) m_cur = 0;
    end else if (!was_sel) begin
      if (ini) begin m_menu = 1; m_cur = 0; end
    end else if (ini) begin
      m_menu = 1;
      m_cur  = 0;
    end else if (e || fire) begin
      m_reg = 1'b1;
    end else if (r && !l) begin
      m_cur = (m_cur + 1) % n_opt(m_menu);
    end else if (l && !r) begin
      m_cur = (m_cur + n_opt(m_menu) - 1) % n_opt(m_menu);
    end
    if (m_menu >= 1 && m_menu <= 4 && !m_reg)
      m_quiet = (was_sel && old_menu == m_menu && !(r | l | e | ini)) ? m_quiet + 1 : 0;
    else
      m_quiet = 0;
  endtask

  task automatic tick(bit r, bit l, bit e, bit ini);
    bus.right_arrow_pressed = r;
    bus.left_arrow_pressed  = l;
    bus.enter_pressed       = e;
    bus.inicia_menu         = ini;
    model_step(r, l, e, ini);
    @(posedge clock);
    #1;
    bus.right_arrow_pressed = 1'b0;
    bus.left_arrow_pressed  = 1'b0;
    bus.enter_pressed       = 1'b0;
    bus.inicia_menu         = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (obs() !== 16'h0) begin
      n_err++;
      $display("FAIL reset_state got %h want %h", obs(), 16'h0);
    end
    do_reset();
    tick(0, 0, 0, 1);
    n_vec++;
    if (obs() !== ev(1, 0, 0, 0, 1)) begin
      n_err++;
      $display("FAIL start_menu got %h want %h", obs(), ev(1, 0, 0, 0, 1));
    end
  endtask

  task automatic test_cursor();
    int exp_r[5] = '{1, 2, 3, 0, 1};
    int exp_l[2] = '{0, 3};
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0, 0);
      n_vec++;
      if (obs() !== ev(1, exp_r[i], 0, 0, 1)) begin
        n_err++;
        $display("FAIL cursor_right_%0d got %h want %h", i, obs(), ev(1, exp_r[i], 0, 0, 1));
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick(0, 1, 0, 0);
      n_vec++;
      if (obs() !== ev(1, exp_l[i], 0, 0, 1)) begin
        n_err++;
        $display("FAIL cursor_left_%0d got %h want %h", i, obs(), ev(1, exp_l[i], 0, 0, 1));
      end
    end
  endtask

  task automatic test_full_walk();
    logic [15:0] want [12];
    do_reset();
    tick(0, 0, 0, 1);
    // Each entry is the expected output after the matching tick below.
    want = '{ev(1, 1, 0, 0, 1), ev(1, 2, 0, 0, 1), ev(1, 2, 8, 0, 2), ev(2, 0, 0, 0, 3),
             ev(2, 1, 0, 0, 3), ev(2, 1, 4, 0, 4), ev(3, 0, 0, 0, 5), ev(3, 0, 2, 0, 6),
             ev(4, 0, 0, 0, 7), ev(4, 15, 0, 0, 7), ev(4, 15, 1, 0, 8), ev(5, 15, 0, 1, 9)};
    for (int i = 0; i < 12; i++) begin
      case (i)
        0, 1, 4: tick(1, 0, 0, 0);
        2, 5, 7, 10: tick(0, 0, 1, 0);
        9: tick(0, 1, 0, 0);
        default: tick(0, 0, 0, 0);
      endcase
      n_vec++;
      if (obs() !== want[i]) begin
        n_err++;
        $display("FAIL walk_step_%0d got %h want %h", i, obs(), want[i]);
      end
    end
    tick(1, 0, 1, 0);
    n_vec++;
    if (obs() !== ev(5, 15, 0, 1, 9)) begin
      n_err++;
      $display("FAIL pronto_ignores_keys got %h want %h", obs(), ev(5, 15, 0, 1, 9));
    end
    tick(0, 0, 0, 1);
    n_vec++;
    if (obs() !== ev(1, 0, 0, 0, 1)) begin
      n_err++;
      $display("FAIL pronto_restart got %h want %h", obs(), ev(1, 0, 0, 0, 1));
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    tick(1, 0, 1, 0);
    n_vec++;
    if (obs() !== 16'h0) begin
      n_err++;
      $display("FAIL idle_ignores_keys got %h want %h", obs(), 16'h0);
    end
    tick(0, 0, 0, 1);
    tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    n_vec++;
    if (obs() !== ev(1, 1, 0, 0, 1)) begin
      n_err++;
      $display("FAIL right_left_hold got %h want %h", obs(), ev(1, 1, 0, 0, 1));
    end
    tick(1, 0, 1, 0);
    n_vec++;
    if (obs() !== ev(1, 1, 8, 0, 2)) begin
      n_err++;
      $display("FAIL right_enter got %h want %h", obs(), ev(1, 1, 8, 0, 2));
    end
    tick(1, 1, 1, 1);
    n_vec++;
    if (obs() !== ev(2, 0, 0, 0, 3)) begin
      n_err++;
      $display("FAIL reg_ignores_inputs got %h want %h", obs(), ev(2, 0, 0, 0, 3));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(0, 0, 0, 1);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
    n_vec++;
    if (obs() !== ev(3, 3, 0, 0, 5)) begin
      n_err++;
      $display("FAIL sel_tom_setup got %h want %h", obs(), ev(3, 3, 0, 0, 5));
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (obs() !== 16'h0) begin
      n_err++;
      $display("FAIL async_reset got %h want %h", obs(), 16'h0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick(0, 0, 0, 1);
    n_vec++;
    if (obs() !== ev(1, 0, 0, 0, 1)) begin
      n_err++;
      $display("FAIL restart_after_reset got %h want %h", obs(), ev(1, 0, 0, 0, 1));
    end
  endtask

`ifdef MENU_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    tick(0, 0, 0, 1);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 1; i <= TO_CYC; i++) begin
      tick(0, 0, 0, 0);
      n_vec++;
      if (obs() !== ((i == TO_CYC) ? ev(2, 1, 4, 0, 4) : ev(2, 1, 0, 0, 3))) begin
        n_err++;
        $display("FAIL timeout_bpm_%0d got %h want %h", i, obs(),
                 (i == TO_CYC) ? ev(2, 1, 4, 0, 4) : ev(2, 1, 0, 0, 3));
      end
    end
    tick(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 1; i <= TO_CYC; i++) begin
      tick(0, 0, 0, 0);
      n_vec++;
      if (obs() !== ((i == TO_CYC) ? ev(3, 1, 2, 0, 6) : ev(3, 1, 0, 0, 5))) begin
        n_err++;
        $display("FAIL timeout_tom_%0d got %h want %h", i, obs(),
                 (i == TO_CYC) ? ev(3, 1, 2, 0, 6) : ev(3, 1, 0, 0, 5));
      end
    end
  endtask
`endif

  task automatic test_random();
    bit r, l, e, ini;
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      r   = ($urandom_range(0, 2) == 0);
      l   = ($urandom_range(0, 2) == 0);
      e   = ($urandom_range(0, 5) == 0);
      ini = ($urandom_range(0, 39) == 0);
      tick(r, l, e, ini);
      n_vec++;
      if (obs() !== model_vec()) begin
        n_err++;
        $display("FAIL random_cycle_%0d got %h want %h", c, obs(), model_vec());
      end
    end
  endtask

  initial begin
    bus.inicia_menu         = 1'b0;
    bus.right_arrow_pressed = 1'b0;
    bus.left_arrow_pressed  = 1'b0;
    bus.enter_pressed       = 1'b0;
    test_reset();
    test_cursor();
    test_full_walk();
    test_simultaneous();
    test_async_reset();
`ifdef MENU_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
